// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock FIFO, STD (dout registered one cycle after rd_en) or FWFT (head prefetched, 2-cycle write-to-visible).
// Writes are dropped while full and reads while empty; defining SYNC_FIFO_ERR_FLAG_EN adds sticky overflow/underflow flags with err_clr.
module sync_fifo_pro #(
   parameter int    DATA_WIDTH = 32,
   parameter int    DATA_DEPTH = 512,
   parameter string MODE       = "STD",
   parameter int    AF_THRESH  = DATA_DEPTH - 2,
   parameter int    AE_THRESH  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [DATA_WIDTH-1:0]       din,
   input  logic                        rd_en,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        dout_valid,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [$clog2(DATA_DEPTH):0] data_cnt
`ifdef SYNC_FIFO_ERR_FLAG_EN
   ,
   input  logic                        err_clr,
   output logic                        overflow,
   output logic                        underflow
`endif
);

   localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam int CW = $clog2(DATA_DEPTH) + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DATA_DEPTH - 1);

   if (DATA_WIDTH < 1 || DATA_DEPTH < 2) begin : g_bad_size
      $error("sync_fifo_pro: DATA_WIDTH must be >= 1 and DATA_DEPTH >= 2");
   end
   if (AF_THRESH < 0 || AF_THRESH > DATA_DEPTH || AE_THRESH < 0 || AE_THRESH >= DATA_DEPTH) begin : g_bad_thresh
      $error("sync_fifo_pro: watermark thresholds out of range for DATA_DEPTH");
   end
   if (MODE != "STD" && MODE != "FWFT") begin : g_bad_mode
      $error("sync_fifo_pro: MODE must be \"STD\" or \"FWFT\"");
   end

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [CW-1:0]         cnt_nxt;

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   assign full         = (data_cnt == DEPTH_C);
   assign almost_full  = (data_cnt >= AF_C);
   assign almost_empty = (data_cnt <= AE_C);
   assign wr_acc       = wr_en && !full;

   always_comb begin
      cnt_nxt = data_cnt;
      if (wr_acc && !rd_acc) begin
         cnt_nxt = data_cnt + CW'(1);
      end else if (!wr_acc && rd_acc) begin
         cnt_nxt = data_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         data_cnt <= '0;
      end else begin
         data_cnt <= cnt_nxt;
         if (wr_acc) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   if (MODE == "FWFT") begin : g_fwft
      logic          out_vld;
      logic [CW-1:0] mem_cnt;
      logic          pop_mem;

      // data_cnt includes the output register, so memory holds the remainder.
      assign mem_cnt    = data_cnt - CW'(out_vld);
      assign rd_acc     = rd_en && out_vld;
      assign pop_mem    = (mem_cnt != '0) && (!out_vld || rd_acc);
      assign empty      = !out_vld;
      assign dout_valid = out_vld;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_ptr  <= '0;
            out_vld <= 1'b0;
            dout    <= '0;
         end else begin
            if (pop_mem) begin
               dout    <= mem[rd_ptr];
               rd_ptr  <= ptr_inc(rd_ptr);
               out_vld <= 1'b1;
            end else if (rd_acc) begin
               out_vld <= 1'b0;
            end
         end
      end
   end else begin : g_std
      assign rd_acc = rd_en && (data_cnt != '0);
      assign empty  = (data_cnt == '0);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
         end else begin
            dout_valid <= rd_acc;
            if (rd_acc) begin
               dout   <= mem[rd_ptr];
               rd_ptr <= ptr_inc(rd_ptr);
            end
         end
      end
   end

`ifdef SYNC_FIFO_ERR_FLAG_EN
   // A new error event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end
`endif

endmodule
